flush_sequencer: RTL and testbench
==================================

FLUSH_SEQUENCER -- requirements
Module: flush_sequencer

Interface
REQ-001 SHALL have parameter FTQ_ID_W, default 3, meaning the FTQ index width (log2 of FTQ depth).
REQ-002 SHALL have parameter FLUSH_HOLD, default 2, range 1..15, meaning the cycles flush_o stays high per request.
REQ-003 SHALL have port clk  in  1  clock; all logic is rising-edge.
REQ-004 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-005 SHALL have port excp_i  in  1, plus excp_target_i  in  32: exception request and its handler PC.
REQ-006 SHALL have port ertn_i  in  1, plus ertn_target_i  in  32: ertn request and its return PC (ERA).
REQ-007 SHALL have port icache_flush_i  in  1, plus icache_pc_i  in  32: cacop request and its refetch PC.
REQ-008 SHALL have port fetch_flush_i  in  1, plus fetch_pc_i  in  32: TLB/CSR refetch request and its refetch PC.
REQ-009 SHALL have port idle_i  in  1, plus idle_pc_i  in  32: idle request and its resume PC (already +4).
REQ-010 SHALL have port flush_ftq_id_i  in  FTQ_ID_W: FTQ id of the committing block.
REQ-011 SHALL have port interrupt_i  in  1: pending enabled interrupt (level).
REQ-012 SHALL have port icache_ack_i  in  1: ICache invalidate-done pulse.
REQ-013 SHALL have port flush_o  out  1: backend pipeline flush.
REQ-014 SHALL have port frontend_stall_o  out  1: block fetch.
REQ-015 SHALL have port icache_req_o  out  1: ICache invalidate request (level until ack).
REQ-016 SHALL have port redirect_valid_o  out  1, plus redirect_pc_o  out  32 and redirect_ftq_id_o  out  FTQ_ID_W: frontend redirect.
REQ-017 SHALL have port busy_o  out  1: state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, HOLD, ICWAIT, SLEEP, REDIR.
REQ-019 In IDLE, any request SHALL be accepted at the clock edge, with priority excp > ertn > icache_flush > fetch_flush > idle.
- Capture: winner's PC into pc_q, flush_ftq_id_i into id_q, and source kind.
- Next state: HOLD.
REQ-020 Lower-priority requests coincident with the winner SHALL be discarded, not queued.
REQ-021 HOLD SHALL drive flush_o=1 for exactly FLUSH_HOLD consecutive cycles via a down-counter loaded on accept. After the last cycle the exit SHALL be:
- icache source: ICWAIT.
- idle source: SLEEP.
- otherwise: REDIR.
REQ-022 ICWAIT SHALL hold icache_req_o=1 until a cycle with icache_ack_i=1, then go to REDIR.
- icache_ack_i outside ICWAIT SHALL be ignored.
REQ-023 In SLEEP:
- excp_i=1: capture excp_target_i and flush_ftq_id_i, then HOLD (re-flush).
- else interrupt_i=1: REDIR with captured pc_q.
- else stay.
REQ-024 REDIR SHALL last exactly one cycle, driving redirect_valid_o=1, redirect_pc_o=pc_q, redirect_ftq_id_o=id_q; then IDLE.
REQ-025 redirect_pc_o and redirect_ftq_id_o SHALL be 0 whenever redirect_valid_o=0.
REQ-026 frontend_stall_o SHALL equal busy_o: 1 in HOLD, ICWAIT, SLEEP, REDIR.
REQ-027 Requests arriving in HOLD, ICWAIT or REDIR SHALL be ignored (the pipeline is already being flushed); only excp_i in SLEEP is honoured.
REQ-028 Minimum request-to-redirect latency SHALL be FLUSH_HOLD+1 cycles (accept edge, HOLD cycles, REDIR cycle); a new request SHALL be acceptable the cycle after REDIR.
REQ-029 All outputs SHALL be registered or decoded from state only, with no combinational path from request inputs.

Reset
REQ-030 rst=1 SHALL force IDLE, clear the counter, pc_q, id_q and source, and drive all outputs 0 at the next edge, including mid-HOLD, ICWAIT or SLEEP.
REQ-031 A request asserted in the same cycle as rst SHALL be dropped.

Verification
REQ-032 Exception: excp_i=1, excp_target_i=0x1C000040, flush_ftq_id_i=5, FLUSH_HOLD=2 -> flush_o high 2 cycles, then redirect_valid_o pulse with pc 0x1C000040, id 5.
REQ-033 Simultaneous requests: ertn_i, fetch_flush_i and idle_i in one cycle -> only the ertn target is redirected; no SLEEP; no second redirect.
REQ-034 Cacop: icache_flush_i, icache_pc_i=0x1C000104; ack after 7 cycles -> icache_req_o high 7 cycles, then a 1-cycle redirect to 0x1C000104.
REQ-035 Idle: idle_i, idle_pc_i=0x1C000200; interrupt_i after 10 cycles -> frontend_stall_o held throughout, redirect to 0x1C000200. Repeat with excp_i in SLEEP -> HOLD again, redirect to excp target.
REQ-036 Reset mid-ICWAIT -> next cycle all outputs 0 and busy_o=0; a late icache_ack_i is ignored.
REQ-037 Back-to-back: second excp_i in the cycle after REDIR -> accepted; excp_i during HOLD -> ignored.

Source files
------------

// File: rtl/flush_sequencer.sv
// flush_sequencer: arbitrates exception/ertn/cacop/refetch/idle requests into a flush, optional ICache wait or sleep, then a one-cycle frontend redirect.
//   Ports: clk, rst (sync, active-high); excp/ertn/icache_flush/fetch_flush/idle requests with target PCs;
//   flush_ftq_id_i, interrupt_i, icache_ack_i in; flush_o, frontend_stall_o, icache_req_o,
//   redirect_valid_o/redirect_pc_o/redirect_ftq_id_o, busy_o out (all decoded from registered state).
module flush_sequencer #(
  parameter int FTQ_ID_W   = 3,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                excp_i,
  input  logic [31:0]         excp_target_i,
  input  logic                ertn_i,
  input  logic [31:0]         ertn_target_i,
  input  logic                icache_flush_i,
  input  logic [31:0]         icache_pc_i,
  input  logic                fetch_flush_i,
  input  logic [31:0]         fetch_pc_i,
  input  logic                idle_i,
  input  logic [31:0]         idle_pc_i,
  input  logic [FTQ_ID_W-1:0] flush_ftq_id_i,
  input  logic                interrupt_i,
  input  logic                icache_ack_i,
  output logic                flush_o,
  output logic                frontend_stall_o,
  output logic                icache_req_o,
  output logic                redirect_valid_o,
  output logic [31:0]         redirect_pc_o,
  output logic [FTQ_ID_W-1:0] redirect_ftq_id_o,
  output logic                busy_o
);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_ICWAIT, S_SLEEP, S_REDIR} state_t;
  typedef enum logic [1:0] {K_OTHER, K_ICACHE, K_IDLE} kind_t;
  localparam logic [3:0] HOLD_LAST = 4'(FLUSH_HOLD - 1);
  state_t              r_state, w_state_nx;
  kind_t               r_kind, w_kind_nx, w_req_kind;
  logic [3:0]          r_cnt, w_cnt_nx;
  logic [31:0]         r_pc, w_pc_nx, w_req_pc;
  logic [FTQ_ID_W-1:0] r_id, w_id_nx;
  logic                w_any_req;
  assign w_any_req  = excp_i | ertn_i | icache_flush_i | fetch_flush_i | idle_i;
  assign w_req_pc   = excp_i ? excp_target_i : ertn_i ? ertn_target_i :
                      icache_flush_i ? icache_pc_i : fetch_flush_i ? fetch_pc_i : idle_pc_i;
  assign w_req_kind = (excp_i | ertn_i) ? K_OTHER : icache_flush_i ? K_ICACHE :
                      fetch_flush_i ? K_OTHER : K_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kind  <= K_OTHER;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_kind  <= w_kind_nx;
      r_cnt   <= w_cnt_nx;
      r_pc    <= w_pc_nx;
      r_id    <= w_id_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_kind_nx  = r_kind;
    w_cnt_nx   = r_cnt;
    w_pc_nx    = r_pc;
    w_id_nx    = r_id;
    case (r_state)
      S_IDLE: if (w_any_req) begin
        w_state_nx = S_HOLD;
        w_kind_nx  = w_req_kind;
        w_cnt_nx   = HOLD_LAST;
        w_pc_nx    = w_req_pc;
        w_id_nx    = flush_ftq_id_i;
      end
      S_HOLD: begin
        w_cnt_nx   = (r_cnt == '0) ? r_cnt : r_cnt - 4'd1;
        w_state_nx = (r_cnt != '0) ? S_HOLD : (r_kind == K_ICACHE) ? S_ICWAIT :
                     (r_kind == K_IDLE) ? S_SLEEP : S_REDIR;
      end
      S_ICWAIT: w_state_nx = icache_ack_i ? S_REDIR : S_ICWAIT;
      S_SLEEP: if (excp_i) begin
        // an exception while asleep restarts the flush towards its handler
        w_state_nx = S_HOLD;
        w_kind_nx  = K_OTHER;
        w_cnt_nx   = HOLD_LAST;
        w_pc_nx    = excp_target_i;
        w_id_nx    = flush_ftq_id_i;
      end else if (interrupt_i) w_state_nx = S_REDIR;
      S_REDIR: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end
  assign flush_o           = r_state == S_HOLD;
  assign icache_req_o      = r_state == S_ICWAIT;
  assign redirect_valid_o  = r_state == S_REDIR;
  assign busy_o            = r_state != S_IDLE;
  assign frontend_stall_o  = busy_o;
  assign redirect_pc_o     = redirect_valid_o ? r_pc : '0;
  assign redirect_ftq_id_o = redirect_valid_o ? r_id : '0;
endmodule

// File: tb/tb_flush_sequencer.sv
// tb_flush_sequencer: directed table-driven and hand-written sequence checks of flush_sequencer.
module tb_flush_sequencer;
  localparam logic [7:0] R = 8'h80, EX = 8'h40, ER = 8'h20, IC = 8'h10, FF = 8'h08, ID = 8'h04, IN = 8'h02, AK = 8'h01;
  localparam logic [4:0] O0 = 5'b00000, OH = 5'b11001, OW = 5'b01101, OS = 5'b01001, OR = 5'b01011;
  localparam logic [31:0] P_EX = 32'h1C000040, P_ER = 32'h1C000080, P_IC = 32'h1C000104,
                          P_FF = 32'h1C000300, P_ID = 32'h1C000200;
  logic clk = 0;
  logic rst, excp, ertn, icf, ff, idl, intr, ack;
  logic [2:0] fid, rid;
  logic flush, stall, icreq, rv, busy;
  logic [31:0] rpc;
  int n_run = 0, n_fail = 0;
  typedef struct {
    logic [7:0]  req;
    logic [2:0]  id;
    logic [4:0]  eo;
    logic [31:0] epc;
    logic [2:0]  eid;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  flush_sequencer #(.FTQ_ID_W(3), .FLUSH_HOLD(2)) dut (
    .clk(clk), .rst(rst),
    .excp_i(excp), .excp_target_i(P_EX),
    .ertn_i(ertn), .ertn_target_i(P_ER),
    .icache_flush_i(icf), .icache_pc_i(P_IC),
    .fetch_flush_i(ff), .fetch_pc_i(P_FF),
    .idle_i(idl), .idle_pc_i(P_ID),
    .flush_ftq_id_i(fid), .interrupt_i(intr), .icache_ack_i(ack),
    .flush_o(flush), .frontend_stall_o(stall), .icache_req_o(icreq),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .redirect_ftq_id_o(rid), .busy_o(busy)
  );
  task automatic push(input logic [7:0] req, input logic [2:0] id, input logic [4:0] eo,
                      input logic [31:0] epc = 0, input logic [2:0] eid = 0);
    tv.push_back('{req, id, eo, epc, eid});
  endtask
  task automatic step(input logic [7:0] req, input logic [2:0] id);
    {rst, excp, ertn, icf, ff, idl, intr, ack} = req;
    fid = id;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string name, input logic [4:0] eo, input logic [31:0] epc, input logic [2:0] eid);
    logic [39:0] act, exp;
    act = {flush, stall, icreq, rv, busy, rpc, rid};
    exp = {eo, epc, eid};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    int n_ic;
    {rst, excp, ertn, icf, ff, idl, intr, ack} = '0;
    fid = '0;
    @(negedge clk);
    push(R, 0, O0);
    push(EX, 5, OH); push(0, 0, OH); push(0, 0, OR, P_EX, 5); push(0, 0, O0);
    push(ER | FF | ID, 2, OH); push(0, 0, OH); push(0, 0, OR, P_ER, 2); push(0, 0, O0); push(0, 0, O0);
    push(EX, 1, OH); push(EX, 3, OH); push(0, 0, OR, P_EX, 1);
    push(EX, 4, O0);
    push(EX, 4, OH); push(0, 0, OH); push(0, 0, OR, P_EX, 4); push(AK, 0, O0);
    push(ID, 1, OH); push(0, 0, OH); push(0, 0, OS); push(IN | ER, 0, OR, P_ID, 1); push(0, 0, O0);
    push(ID, 1, OH); push(0, 0, OH); push(AK | FF, 0, OS); push(EX, 3, OH); push(0, 0, OH);
    push(0, 0, OR, P_EX, 3); push(0, 0, O0);
    push(IC | FF, 2, OH); push(0, 0, OH); push(0, 0, OW); push(R | EX, 1, O0); push(AK, 0, O0); push(0, 0, O0);
    push(EX, 6, OH); push(R, 0, O0); push(0, 0, O0);
    push(FF | ID, 3, OH); push(0, 0, OH); push(0, 0, OR, P_FF, 3); push(0, 0, O0);
    foreach (tv[i]) begin
      step(tv[i].req, tv[i].id);
      check($sformatf("vec%0d", i), tv[i].eo, tv[i].epc, tv[i].eid);
    end
    step(IC, 6);
    check("cacop_accept", OH, 0, 0);
    n_ic = 0;
    for (int k = 0; k < 40 && !rv; k++) begin
      step(n_ic == 7 ? AK : 8'h00, 0);
      if (icreq) n_ic++;
    end
    n_run++;
    if (n_ic != 7) begin
      n_fail++;
      $display("FAIL cacop_icreq_cycles: got %0d want 7", n_ic);
    end
    check("cacop_redirect", OR, P_IC, 6);
    step(0, 0);
    check("cacop_done", O0, 0, 0);
    step(ID, 7);
    step(0, 0);
    step(0, 0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("sleep%0d", k), OS, 0, 0);
      step(0, 0);
    end
    step(IN, 0);
    check("idle_wake", OR, P_ID, 7);
    step(0, 0);
    check("idle_done", O0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
